// File: rtl/nios_design_debug_scan_master.sv
// Fabric-side initiator for the Nios II debug-slave virtual-JTAG port.
// Sequences UIR/CDR/SDR/UDR phases with a divided tck and returns the captured tdo and ir_out.
module nios_design_debug_scan_master #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    localparam int PW = $clog2(TCK_DIV);
    localparam int IW = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RSP} state_t;

    state_t              state;
    state_t              state_nx;
    logic [PW-1:0]       phase_cnt;
    logic [IW-1:0]       bit_idx;
    logic [IR_WIDTH-1:0] ir_lat;
    logic [SR_WIDTH-1:0] data_lat;
    logic [SR_WIDTH-1:0] capture;
    logic                ir_valid;
    logic                accept;
    logic                in_phase;
    logic                phase_last;
    logic                bit_last;

    assign accept     = cmd_valid & cmd_ready;
    assign in_phase   = (state == UIR) || (state == CDR) || (state == SDR) || (state == UDR);
    assign phase_last = (phase_cnt == PW'(TCK_DIV - 1));
    assign bit_last   = (bit_idx == IW'(SR_WIDTH - 1));

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (ir_valid && (cmd_ir == ir_in)) ? CDR : UIR;
            UIR:  if (phase_last) state_nx = CDR;
            CDR:  if (phase_last) state_nx = SDR;
            SDR:  if (phase_last && bit_last) state_nx = UDR;
            UDR:  if (phase_last) state_nx = RSP;
            RSP:  if (rsp_valid && rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready      = 1'b0;
        jtag_state_rti = 1'b0;
        vs_uir         = 1'b0;
        vs_cdr         = 1'b0;
        vs_sdr         = 1'b0;
        vs_udr         = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready      = 1'b1;
                jtag_state_rti = 1'b1;
            end
            UIR: vs_uir = 1'b1;
            CDR: vs_cdr = 1'b1;
            SDR: vs_sdr = 1'b1;
            UDR: vs_udr = 1'b1;
            default: ;
        endcase
        // Low half of each phase, then high half; parked low outside scan phases.
        tck = in_phase && (phase_cnt >= PW'(TCK_DIV / 2));
    end

    // NOTE: the capture register is reset with everything else; it is small and keeps sim X-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_cnt  <= '0;
            bit_idx    <= '0;
            ir_lat     <= '0;
            data_lat   <= '0;
            capture    <= '0;
            ir_valid   <= 1'b0;
            ir_in      <= '0;
            tdi        <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ir_out <= '0;
        end else begin
            if (in_phase) phase_cnt <= phase_last ? '0 : phase_cnt + PW'(1);
            else          phase_cnt <= '0;

            case (state)
                IDLE: if (accept) begin
                    ir_lat   <= cmd_ir;
                    data_lat <= cmd_data;
                end
                UIR: begin
                    if (phase_cnt == '0) ir_in <= ir_lat;
                    if (phase_last)      ir_valid <= 1'b1;
                end
                CDR: if (phase_last) begin
                    rsp_ir_out <= ir_out;
                    bit_idx    <= '0;
                end
                SDR: begin
                    // tdi settles before the tck rise; tdo is taken at the end of the high half.
                    if (phase_cnt == '0) tdi <= data_lat[bit_idx];
                    if (phase_last) begin
                        capture[bit_idx] <= tdo;
                        if (bit_last) begin
                            bit_idx <= '0;
                            tdi     <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
                UDR: begin
                    tdi <= 1'b0;
                    if (phase_last) begin
                        rsp_data  <= capture;
                        rsp_valid <= 1'b1;
                    end
                end
                RSP: if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_design_debug_scan_master.sv
// Self-checking bench for nios_design_debug_scan_master: a constant vector table,
// hand-written reset/hold sequences and randomized commands against a transaction-level model.
module tb_nios_design_debug_scan_master;

    localparam int SR = 38;
    localparam int IR = 2;
    localparam int DIV = 4;

    logic          clk;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [IR-1:0] cmd_ir;
    logic [SR-1:0] cmd_data;
    logic          rsp_valid, rsp_ready;
    logic [SR-1:0] rsp_data;
    logic [IR-1:0] rsp_ir_out;
    logic          tck, tdi, tdo;
    logic [IR-1:0] ir_in, ir_out;
    logic          vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;
    logic          tdo_inv;

    // Second instance: TCK_DIV=2 with tdo tied high.
    logic          d2_cmd_valid, d2_cmd_ready;
    logic [IR-1:0] d2_cmd_ir;
    logic [SR-1:0] d2_cmd_data;
    logic          d2_rsp_valid, d2_rsp_ready;
    logic [SR-1:0] d2_rsp_data;
    logic [IR-1:0] d2_rsp_ir_out;
    logic          d2_tck, d2_tdi;
    logic [IR-1:0] d2_ir_in;
    logic          d2_vs_uir, d2_vs_cdr, d2_vs_sdr, d2_vs_udr, d2_rti;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: UIR is skipped only when the last completed IR matches.
    logic          m_ir_valid;
    logic [IR-1:0] m_ir;

    typedef struct {
        logic [IR-1:0] ir;
        logic [SR-1:0] data;
        logic [IR-1:0] ir_out;
        logic          inv;
        int            rdy_delay;
        logic          exp_uir;
        int            exp_lat;
        logic [SR-1:0] exp_data;
    } vec_t;

    vec_t tbl[5];

    assign tdo = tdi ^ tdo_inv;

    nios_design_debug_scan_master #(.SR_WIDTH(SR), .IR_WIDTH(IR), .TCK_DIV(DIV)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out),
        .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
        .jtag_state_rti(jtag_state_rti)
    );

    nios_design_debug_scan_master #(.SR_WIDTH(SR), .IR_WIDTH(IR), .TCK_DIV(2)) dut2 (
        .clk(clk), .reset(reset),
        .cmd_valid(d2_cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_ir(d2_cmd_ir), .cmd_data(d2_cmd_data),
        .rsp_valid(d2_rsp_valid), .rsp_ready(d2_rsp_ready), .rsp_data(d2_rsp_data),
        .rsp_ir_out(d2_rsp_ir_out),
        .tck(d2_tck), .tdi(d2_tdi), .tdo(1'b1), .ir_in(d2_ir_in), .ir_out(2'b00),
        .vs_uir(d2_vs_uir), .vs_cdr(d2_vs_cdr), .vs_sdr(d2_vs_sdr), .vs_udr(d2_vs_udr),
        .jtag_state_rti(d2_rti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic run_cmd(input logic [IR-1:0] ir, input logic [SR-1:0] data,
                           input logic [IR-1:0] iro, input logic inv, input int rdy_delay,
                           input logic exp_uir, input int exp_lat, input logic [SR-1:0] exp_data);
        int   cyc;
        int   rises;
        int   viol;
        logic saw_uir;
        logic prev_tck;
        logic got_tdi;
        logic first_tdi;
        ir_out    = iro;
        tdo_inv   = inv;
        cmd_ir    = ir;
        cmd_data  = data;
        cmd_valid = 1'b1;
        rsp_ready = (rdy_delay == 0);
        check("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_ir    = ~ir;
        cmd_data  = ~data;
        cyc = 1; rises = 0; viol = 0; saw_uir = 0; prev_tck = 0; got_tdi = 0; first_tdi = 0;
        while (!rsp_valid && cyc < 400) begin
            if (tck && !prev_tck) rises++;
            prev_tck = tck;
            if (vs_uir) saw_uir = 1'b1;
            if (int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_udr) != 1) viol++;
            if (!got_tdi && vs_sdr && tck) begin
                got_tdi   = 1'b1;
                first_tdi = tdi;
            end
            tick();
            cyc++;
        end
        check("rsp_valid_rise", rsp_valid, 1);
        check("latency", cyc, exp_lat);
        check("uir_issued", saw_uir, exp_uir);
        check("tck_rises", rises, exp_uir ? SR + 3 : SR + 2);
        check("vs_onehot", viol, 0);
        check("first_sdr_tdi", first_tdi, data[0]);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_ir_out", rsp_ir_out, iro);
        check("ir_in", ir_in, ir);
        check("busy_cmd_ready", cmd_ready, 0);
        check("busy_rti", jtag_state_rti, 0);
        if (rdy_delay > 0) begin
            cmd_valid = 1'b1;
            cmd_ir    = ~ir;
            cmd_data  = {6'($urandom), 32'($urandom)};
            for (int k = 0; k < rdy_delay; k++) begin
                tick();
                check("hold_valid", rsp_valid, 1);
                check("hold_data", rsp_data, exp_data);
                check("hold_cmd_ready", cmd_ready, 0);
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        tick();
        rsp_ready = 1'b0;
        check("rsp_done_valid", rsp_valid, 0);
        check("rsp_done_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        logic [IR-1:0] r_ir;
        logic [SR-1:0] r_data;
        logic [IR-1:0] r_iro;
        logic          r_inv;
        logic          r_uir;
        int            cyc;

        tbl[0] = '{2'b01, 38'h2A_5555_AAAA, 2'b00, 1'b0, 0,  1'b1, 165, 38'h2A_5555_AAAA};
        tbl[1] = '{2'b01, 38'h00_0000_0000, 2'b00, 1'b0, 0,  1'b0, 161, 38'h00_0000_0000};
        tbl[2] = '{2'b11, 38'h15_0F0F_3C3C, 2'b10, 1'b0, 20, 1'b1, 165, 38'h15_0F0F_3C3C};
        tbl[3] = '{2'b11, 38'h3F_0000_0001, 2'b01, 1'b1, 3,  1'b0, 161, 38'h00_FFFF_FFFE};
        tbl[4] = '{2'b00, 38'h20_0000_0000, 2'b11, 1'b0, 1,  1'b1, 165, 38'h20_0000_0000};

        reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b0;
        ir_out = '0; tdo_inv = 1'b0;
        d2_cmd_valid = 1'b0; d2_cmd_ir = '0; d2_cmd_data = '0; d2_rsp_ready = 1'b1;
        m_ir_valid = 1'b0; m_ir = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_ir_out", rsp_ir_out, 0);
        check("rst_tck", tck, 0);
        check("rst_tdi", tdi, 0);
        check("rst_ir_in", ir_in, 0);
        check("rst_vs", {vs_uir, vs_cdr, vs_sdr, vs_udr}, 0);
        check("rst_rti", jtag_state_rti, 1);

        for (int i = 0; i < 5; i++) begin
            run_cmd(tbl[i].ir, tbl[i].data, tbl[i].ir_out, tbl[i].inv, tbl[i].rdy_delay,
                    tbl[i].exp_uir, tbl[i].exp_lat, tbl[i].exp_data);
            m_ir_valid = 1'b1;
            m_ir       = tbl[i].ir;
        end

        // Reset in the middle of SDR bit 17 of an IR-skip command.
        cmd_ir = m_ir; cmd_data = {6'($urandom), 32'($urandom)};
        ir_out = 2'b00; tdo_inv = 1'b0; rsp_ready = 1'b0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cyc = 1;
        while (cyc < 75) begin
            tick();
            cyc++;
        end
        check("mid_sdr_bit17", vs_sdr, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_vs", {vs_uir, vs_cdr, vs_sdr, vs_udr}, 0);
        check("mid_rst_tck", tck, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_ir_in", ir_in, 0);
        check("mid_rst_rti", jtag_state_rti, 1);
        m_ir_valid = 1'b0;
        repeat (8) tick();
        check("mid_rst_no_rsp", rsp_valid, 0);
        run_cmd(m_ir, 38'h12_3456_789A, 2'b01, 1'b0, 0, 1'b1, 165, 38'h12_3456_789A);
        m_ir_valid = 1'b1;

        // Randomized commands checked against the transaction model.
        for (int i = 0; i < 16; i++) begin
            r_ir   = ($urandom_range(0, 1) != 0) ? m_ir : IR'($urandom_range(0, 3));
            r_data = {6'($urandom), 32'($urandom)};
            r_iro  = IR'($urandom_range(0, 3));
            r_inv  = 1'($urandom_range(0, 1));
            r_uir  = !(m_ir_valid && (r_ir == m_ir));
            run_cmd(r_ir, r_data, r_iro, r_inv, $urandom_range(0, 3), r_uir,
                    1 + (SR + (r_uir ? 3 : 2)) * DIV, r_data ^ {SR{r_inv}});
            m_ir_valid = 1'b1;
            m_ir       = r_ir;
        end

        // TCK_DIV=2 instance, tdo tied high.
        check("d2_idle_ready", d2_cmd_ready, 1);
        d2_cmd_ir = 2'b10; d2_cmd_data = {6'($urandom), 32'($urandom)}; d2_cmd_valid = 1'b1;
        tick();
        d2_cmd_valid = 1'b0;
        cyc = 1;
        while (!d2_rsp_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        check("d2_latency", cyc, 83);
        check("d2_rsp_data", d2_rsp_data, 38'h3F_FFFF_FFFF);
        tick();
        check("d2_done_ready", d2_cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nios_design_debug_scan_master.md
Name: nios_design_debug_scan_master

Overview:
- Initiator end of the Nios II debug-slave virtual-JTAG interface.
- Accepts a 2-bit instruction plus 38-bit data command from a host-side engine (test harness or on-chip debug bridge).
- Sequences UIR/CDR/SDR/UDR virtual states and shifts data out on tdi with a generated tck. Captures tdo and ir_out, then returns them as a response.
- Replaces the virtual-JTAG hub when the debug slave is driven from fabric. Runs entirely in the clk domain.

Parameters:
- SR_WIDTH, 38, data-register scan length in bits.
- IR_WIDTH, 2, instruction width.
- TCK_DIV, 4, clk cycles per tck period; must be even and >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master idle, command accepted when cmd_valid & cmd_ready.
- cmd_ir  in  IR_WIDTH  instruction to load.
- cmd_data  in  SR_WIDTH  data to shift, LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  SR_WIDTH  captured tdo bits; bit0 = first sampled.
- rsp_ir_out  out  IR_WIDTH  ir_out sampled during CDR.
- tck  out  1  generated scan clock.
- tdi  out  1  serial data to slave.
- tdo  in  1  serial data from slave.
- ir_in  out  IR_WIDTH  registered instruction presented to slave.
- ir_out  in  IR_WIDTH  slave status word.
- vs_uir, vs_cdr, vs_sdr, vs_udr  out  1 each  virtual-state indicators.
- jtag_state_rti  out  1  high while in IDLE.

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_ir_out=0, tck=0, tdi=0, ir_in=0, all vs_* =0, jtag_state_rti=1. Internal ir_valid=0.
- States: IDLE, UIR, CDR, SDR, UDR, RSP.
- Phase timing:
  - Each UIR/CDR/SDR-bit/UDR phase lasts exactly TCK_DIV clk cycles, counted by a phase counter 0..TCK_DIV-1.
  - tck=0 for counts 0..TCK_DIV/2-1 and tck=1 for the rest. tck is forced 0 outside these states.
- IDLE:
  - cmd_ready=1, jtag_state_rti=1.
  - On accept, latch cmd_ir and cmd_data.
  - If ir_valid and cmd_ir==ir_in, go to CDR (IR skip). Otherwise go to UIR.
- UIR:
  - ir_in<=latched ir on the first cycle; vs_uir=1 for the whole phase.
  - On exit set ir_valid=1, then go to CDR.
- CDR:
  - vs_cdr=1 for the whole phase.
  - On the last phase cycle, rsp_ir_out<=ir_out. Go to SDR with bit index 0.
- SDR:
  - vs_sdr=1 throughout.
  - tdi<=data[idx] at phase count 0.
  - On the last phase cycle, capture[idx]<=tdo.
  - After idx==SR_WIDTH-1, go to UDR.
- UDR:
  - vs_udr=1 for the whole phase; tdi=0.
  - On exit, rsp_data<=capture and rsp_valid=1, then go to RSP.
- RSP:
  - Hold rsp_valid, rsp_data and rsp_ir_out stable until rsp_valid & rsp_ready.
  - Then rsp_valid=0 on the next cycle and return to IDLE. cmd_ready stays 0 until IDLE.
- Exactly one vs_* is high at any time; none in IDLE or RSP.
- Latency, counting the accept cycle as 0:
  - rsp_valid rises at cycle 1+(SR_WIDTH+3)*TCK_DIV when UIR is issued (165 at defaults).
  - 1+(SR_WIDTH+2)*TCK_DIV when UIR is skipped (161).
- rsp_ready high in the same cycle rsp_valid rises completes the handshake in that cycle.
- cmd_valid outside IDLE is ignored; cmd inputs are sampled only at accept.
- Reset mid-operation:
  - Next cycle returns to IDLE with all outputs at reset values; ir_valid=0.
  - The partial scan is discarded and no response is issued.
- The bit index wraps only via the SDR→UDR transition. No partial-length scans.

Test Plan:
- Reset, then cmd ir=2'b01, data=38'h2A_5555_AAAA with tdo looped to tdi:
  - vs_uir phase seen, ir_in=01.
  - rsp_valid at cycle 165, rsp_data=38'h2A_5555_AAAA.
- Second command, same ir=01, data=0:
  - No vs_uir pulse.
  - rsp_valid at cycle 161.
  - rsp_data=0.
- ir_out tied to 2'b10, ir=2'b11:
  - rsp_ir_out=2'b10.
  - tck shows exactly 41 rising edges per command.
  - tdi bit0 appears in the first SDR period.
- rsp_ready held low 20 cycles after rsp_valid:
  - rsp_data stable, cmd_ready=0, new cmd_valid ignored.
  - After rsp_ready pulse, cmd_ready=1 next cycle.
- reset asserted during SDR bit 17:
  - Next cycle all vs_*=0, tck=0, rsp_valid=0, cmd_ready=1.
  - Following command with the same ir still issues UIR.
- TCK_DIV=2 build, tdo tied 1:
  - rsp_data=38'h3F_FFFF_FFFF.
  - Latency 83 cycles with UIR.
